// File: rtl/rx_cmd_decoder.sv
// UART RX command-frame decoder: turns a byte stream into register-file and ALU strobes.
// Optional inter-byte timeout enabled by defining CMD_TIMEOUT_EN.
module rx_cmd_decoder #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned FUN_WIDTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rf_wr_en,
  output logic                  rf_rd_en,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  output logic                  alu_en,
  output logic [FUN_WIDTH-1:0]  alu_fun,
  output logic                  clk_gate_en,
  output logic                  busy,
  output logic                  frame_err
);

  localparam logic [DATA_WIDTH-1:0] CmdWr  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CmdRd  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CmdOp  = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CmdAlu = DATA_WIDTH'(8'hDD);

  typedef enum logic [2:0] {
    StIdle, StWrAddr, StWrData, StRdAddr, StOpA, StOpB, StAluFun
  } state_e;

  state_e                state_q, state_d;
  logic                  rf_wr_en_q, rf_wr_en_d;
  logic                  rf_rd_en_q, rf_rd_en_d;
  logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_WIDTH-1:0] rf_wr_data_q, rf_wr_data_d;
  logic                  alu_en_q, alu_en_d;
  logic [FUN_WIDTH-1:0]  alu_fun_q, alu_fun_d;
  logic                  clk_gate_en_q, clk_gate_en_d;
  logic                  frame_err_q, frame_err_d;

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] tmo_q, tmo_d;
`endif

  always_comb begin
    state_d      = state_q;
    rf_addr_d    = rf_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    alu_fun_d    = alu_fun_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    alu_en_d     = 1'b0;
    frame_err_d  = 1'b0;

    if (rx_valid) begin
      case (state_q)
        StIdle: begin
          // Anything other than a known command is rejected without leaving IDLE.
          case (rx_data)
            CmdWr:   state_d = StWrAddr;
            CmdRd:   state_d = StRdAddr;
            CmdOp:   state_d = StOpA;
            CmdAlu:  state_d = StAluFun;
            default: frame_err_d = 1'b1;
          endcase
        end
        StWrAddr: begin
          rf_addr_d = rx_data[ADDR_WIDTH-1:0];
          state_d   = StWrData;
        end
        StWrData: begin
          rf_wr_data_d = rx_data;
          rf_wr_en_d   = 1'b1;
          state_d      = StIdle;
        end
        StRdAddr: begin
          rf_addr_d  = rx_data[ADDR_WIDTH-1:0];
          rf_rd_en_d = 1'b1;
          state_d    = StIdle;
        end
        StOpA: begin
          rf_addr_d    = '0;
          rf_wr_data_d = rx_data;
          rf_wr_en_d   = 1'b1;
          state_d      = StOpB;
        end
        StOpB: begin
          rf_addr_d    = ADDR_WIDTH'(1);
          rf_wr_data_d = rx_data;
          rf_wr_en_d   = 1'b1;
          state_d      = StAluFun;
        end
        StAluFun: begin
          alu_fun_d = rx_data[FUN_WIDTH-1:0];
          alu_en_d  = 1'b1;
          state_d   = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end

`ifdef CMD_TIMEOUT_EN
    tmo_d = '0;
    if (!rx_valid && state_q != StIdle) begin
      if (tmo_q == CntW'(TIMEOUT_CYCLES - 1)) begin
        state_d     = StIdle;
        frame_err_d = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`endif

    clk_gate_en_d = (state_d inside {StOpA, StOpB, StAluFun}) || alu_en_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      rf_wr_en_q    <= 1'b0;
      rf_rd_en_q    <= 1'b0;
      rf_addr_q     <= '0;
      rf_wr_data_q  <= '0;
      alu_en_q      <= 1'b0;
      alu_fun_q     <= '0;
      clk_gate_en_q <= 1'b0;
      frame_err_q   <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      tmo_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      rf_wr_en_q    <= rf_wr_en_d;
      rf_rd_en_q    <= rf_rd_en_d;
      rf_addr_q     <= rf_addr_d;
      rf_wr_data_q  <= rf_wr_data_d;
      alu_en_q      <= alu_en_d;
      alu_fun_q     <= alu_fun_d;
      clk_gate_en_q <= clk_gate_en_d;
      frame_err_q   <= frame_err_d;
`ifdef CMD_TIMEOUT_EN
      tmo_q         <= tmo_d;
`endif
    end
  end

  assign rf_wr_en    = rf_wr_en_q;
  assign rf_rd_en    = rf_rd_en_q;
  assign rf_addr     = rf_addr_q;
  assign rf_wr_data  = rf_wr_data_q;
  assign alu_en      = alu_en_q;
  assign alu_fun     = alu_fun_q;
  assign clk_gate_en = clk_gate_en_q;
  assign frame_err   = frame_err_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_rx_cmd_decoder.sv
// Directed testbench for rx_cmd_decoder; checks strobes and held outputs after each byte.
module tb_rx_cmd_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rf_wr_en, rf_rd_en, alu_en, clk_gate_en, busy, frame_err;
  logic [3:0] rf_addr, alu_fun;
  logic [7:0] rf_wr_data;

  int n_tests = 0;
  int n_fail  = 0;

  rx_cmd_decoder #(
    .DATA_WIDTH    (8),
    .ADDR_WIDTH    (4),
    .FUN_WIDTH     (4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rf_wr_en   (rf_wr_en),
    .rf_rd_en   (rf_rd_en),
    .rf_addr    (rf_addr),
    .rf_wr_data (rf_wr_data),
    .alu_en     (alu_en),
    .alu_fun    (alu_fun),
    .clk_gate_en(clk_gate_en),
    .busy       (busy),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one byte for a single cycle; returns at the next falling edge, where the
  // registered response to that byte is visible.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic chk_strobes(input string tag, input logic wr, input logic rd,
                             input logic alu, input logic err);
    chk({tag, ".wr_en"}, rf_wr_en, wr);
    chk({tag, ".rd_en"}, rf_rd_en, rd);
    chk({tag, ".alu_en"}, alu_en, alu);
    chk({tag, ".frame_err"}, frame_err, err);
  endtask

  initial begin
    // Reset state
    #12;
    chk_strobes("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.rf_addr", rf_addr, 0);
    chk("reset.rf_wr_data", rf_wr_data, 0);
    chk("reset.alu_fun", alu_fun, 0);
    chk("reset.clk_gate", clk_gate_en, 0);
    chk("reset.busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;

    // 1: RF write
    send(8'hAA);
    chk("t1.busy_aa", busy, 1);
    chk_strobes("t1.aa", 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'h05);
    chk("t1.addr_latched", rf_addr, 5);
    chk_strobes("t1.addr", 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'h3C);
    chk_strobes("t1.data", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t1.rf_addr", rf_addr, 5);
    chk("t1.rf_wr_data", rf_wr_data, 8'h3C);
    chk("t1.busy_after", busy, 0);
    chk("t1.clk_gate", clk_gate_en, 0);
    @(negedge clk);
    chk("t1.wr_en_one_cycle", rf_wr_en, 0);

    // 2: RF read, upper address bits dropped
    send(8'hBB);
    send(8'h17);
    chk_strobes("t2.rd", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t2.rf_addr", rf_addr, 7);
    chk("t2.busy", busy, 0);
    @(negedge clk);
    chk("t2.rd_en_one_cycle", rf_rd_en, 0);

    // 3: operand load then ALU op
    send(8'hCC);
    chk("t3.cg_after_cc", clk_gate_en, 1);
    chk("t3.busy_cc", busy, 1);
    send(8'h12);
    chk_strobes("t3.opa", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t3.opa_addr", rf_addr, 0);
    chk("t3.opa_data", rf_wr_data, 8'h12);
    chk("t3.cg_opa", clk_gate_en, 1);
    send(8'h34);
    chk_strobes("t3.opb", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t3.opb_addr", rf_addr, 1);
    chk("t3.opb_data", rf_wr_data, 8'h34);
    send(8'h02);
    chk_strobes("t3.fun", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3.alu_fun", alu_fun, 2);
    chk("t3.cg_alu_cycle", clk_gate_en, 1);
    chk("t3.busy_after", busy, 0);
    @(negedge clk);
    chk("t3.cg_off", clk_gate_en, 0);
    chk("t3.alu_en_one_cycle", alu_en, 0);
    chk("t3.alu_fun_held", alu_fun, 2);

    // 4: bad command, then short ALU frame
    send(8'h5A);
    chk_strobes("t4.bad", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t4.busy_bad", busy, 0);
    @(negedge clk);
    chk("t4.err_one_cycle", frame_err, 0);
    send(8'hDD);
    chk("t4.busy_dd", busy, 1);
    chk("t4.cg_dd", clk_gate_en, 1);
    send(8'h03);
    chk_strobes("t4.fun", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t4.alu_fun", alu_fun, 3);

    // Command-valued bytes inside a frame are data
    send(8'hAA);
    send(8'hBB);
    send(8'hCC);
    chk_strobes("mid.wr", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("mid.rf_addr", rf_addr, 4'hB);
    chk("mid.rf_wr_data", rf_wr_data, 8'hCC);
    chk("mid.busy", busy, 0);

    // 5: reset mid-frame
    send(8'hAA);
    send(8'h05);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t5.busy_rst", busy, 0);
    chk("t5.addr_rst", rf_addr, 0);
    rst = 1'b1;
    send(8'h3C);
    chk_strobes("t5.after", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t5.busy", busy, 0);

`ifdef CMD_TIMEOUT_EN
    // 6: inter-byte timeout after 16 idle cycles
    begin
      int n = 0;
      send(8'hAA);
      while (n < 40 && frame_err !== 1'b1) begin
        @(negedge clk);
        n++;
      end
      chk("t6.timeout_cycle", n, 16);
      chk_strobes("t6.timeout", 1'b0, 1'b0, 1'b0, 1'b1);
      chk("t6.busy", busy, 0);
      send(8'hAA);
      send(8'h01);
      send(8'hFF);
      chk_strobes("t6.wr", 1'b1, 1'b0, 1'b0, 1'b0);
      chk("t6.rf_addr", rf_addr, 1);
      chk("t6.rf_wr_data", rf_wr_data, 8'hFF);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
